// File: rtl/channel_demapping.sv
// Logical-to-physical channel demapper: validates a loaded forward map as a permutation,
// inverts it, blanks the valids for a few cycles, then swaps the inverse table atomically.
module channel_demapping #(
  parameter int unsigned NUM_CHANNELS  = 8,
  parameter int unsigned CHANNEL_WIDTH = 16,
  parameter int unsigned BLANK_CYCLES  = 4
) (
  input  logic                                  clk,
  input  logic                                  resetN,
  input  logic                                  mapStrobe,
  input  logic [31:0]                           mapIn,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] logicalData,
  input  logic [NUM_CHANNELS-1:0]               logicalValid,
  output logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] physicalData,
  output logic [NUM_CHANNELS-1:0]               physicalValid,
  output logic [31:0]                           activeMap,
  output logic                                  mapBusy,
  output logic                                  mapError,
  output logic                                  mapDropped
);

  localparam int unsigned CNTW     = $clog2(BLANK_CYCLES + 1);
  localparam logic [31:0] MAP_MASK = 32'((64'd1 << (3 * NUM_CHANNELS)) - 64'd1);
  localparam logic [2:0]  LAST_IDX = 3'(NUM_CHANNELS - 1);

  function automatic logic [31:0] identityMap();
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) m[3*i +: 3] = 3'(i);
    return m;
  endfunction

  localparam logic [31:0] IDENTITY = identityMap();

  typedef enum logic [1:0] {IDLE, CHECK, BLANK} state_t;

  state_t                   state, stateNext;
  logic [31:0]              pending;
  logic [2:0]               scratch [8];
  logic [2:0]               inv     [8];
  logic [7:0]               seen;
  logic [2:0]               idx;
  logic                     bad;
  logic [CNTW-1:0]          cnt;
  logic [2:0]               fields  [8];
  logic [2:0]               field;
  logic                     fieldBad;
  logic                     reject;
  logic                     commit;
  logic                     blank;
  logic [CHANNEL_WIDTH-1:0] lData   [8];
  logic [7:0]               lValid;

  // Pad the logical side to 8 lanes so the 3-bit inverse entries index it directly.
  for (genvar i = 0; i < 8; i++) begin : gPad
    if (i < NUM_CHANNELS) begin : gUsed
      assign lData[i] = logicalData[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end else begin : gUnused
      assign lData[i] = '0;
    end
  end
  assign lValid = 8'(logicalValid);

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) fields[i] = pending[3*i +: 3];
    field    = fields[idx];
    fieldBad = (32'(field) >= 32'(NUM_CHANNELS)) || seen[field];
  end

  always_comb begin
    stateNext = state;
    reject    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE:  if (mapStrobe) stateNext = CHECK;
      CHECK: if (idx == LAST_IDX) begin
        if (bad || fieldBad) begin
          stateNext = IDLE;
          reject    = 1'b1;
        end else begin
          stateNext = BLANK;
        end
      end
      BLANK: if (cnt == '0) begin
        stateNext = IDLE;
        commit    = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign blank   = (state == BLANK);
  assign mapBusy = (state != IDLE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending    <= '0;
      seen       <= '0;
      idx        <= '0;
      bad        <= 1'b0;
      cnt        <= '0;
      activeMap  <= IDENTITY;
      mapError   <= 1'b0;
      mapDropped <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        scratch[i] <= '0;
        inv[i]     <= 3'(i);
      end
    end else begin
      case (state)
        IDLE: if (mapStrobe) begin
          pending <= mapIn & MAP_MASK;
          seen    <= '0;
          idx     <= '0;
          bad     <= 1'b0;
          for (int unsigned i = 0; i < 8; i++) scratch[i] <= '0;
        end
        CHECK: begin
          if (fieldBad) begin
            bad <= 1'b1;
          end else begin
            seen[field]    <= 1'b1;
            scratch[field] <= idx;
          end
          idx <= idx + 3'd1;
          cnt <= CNTW'(BLANK_CYCLES - 1);
        end
        BLANK: cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (mapBusy && mapStrobe) mapDropped <= 1'b1;
      if (reject) mapError <= 1'b1;
      // Commit is last so it wins over a strobe dropped on the same edge.
      if (commit) begin
        for (int unsigned i = 0; i < 8; i++) inv[i] <= scratch[i];
        activeMap  <= pending;
        mapError   <= 1'b0;
        mapDropped <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      physicalData  <= '0;
      physicalValid <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_CHANNELS; j++) begin
        physicalData[j*CHANNEL_WIDTH +: CHANNEL_WIDTH] <= lData[inv[j]];
        physicalValid[j] <= lValid[inv[j]] & ~blank;
      end
    end
  end

endmodule

// File: tb/tb_channel_demapping.sv
// Directed bench for channel_demapping: an 8-channel instance plus a 4-channel instance
// for out-of-range map fields.
module tb_channel_demapping;

  logic         clk = 1'b0;
  logic         resetN;
  logic         mapStrobe, mapStrobe4;
  logic [31:0]  mapIn, mapIn4;
  logic [127:0] logicalData, physicalData;
  logic [7:0]   logicalValid, physicalValid;
  logic [31:0]  activeMap;
  logic         mapBusy, mapError, mapDropped;
  logic [63:0]  logicalData4, physicalData4;
  logic [3:0]   logicalValid4, physicalValid4;
  logic [31:0]  activeMap4;
  logic         mapBusy4, mapError4, mapDropped4;

  logic [127:0] expId, expRev;
  logic [63:0]  expRev4;
  int unsigned  checks = 0;
  int unsigned  failures = 0;

  localparam logic [31:0] ID8  = 32'h00FAC688;
  localparam logic [31:0] REV8 = 32'h00053977;
  localparam logic [31:0] DUP8 = 32'h00FAC692;
  localparam logic [31:0] ID4  = 32'h00000688;

  always #5 clk = ~clk;

  channel_demapping #(.NUM_CHANNELS(8), .CHANNEL_WIDTH(16), .BLANK_CYCLES(4)) dut (
    .clk(clk), .resetN(resetN), .mapStrobe(mapStrobe), .mapIn(mapIn),
    .logicalData(logicalData), .logicalValid(logicalValid),
    .physicalData(physicalData), .physicalValid(physicalValid),
    .activeMap(activeMap), .mapBusy(mapBusy), .mapError(mapError), .mapDropped(mapDropped)
  );

  channel_demapping #(.NUM_CHANNELS(4), .CHANNEL_WIDTH(16), .BLANK_CYCLES(4)) dut4 (
    .clk(clk), .resetN(resetN), .mapStrobe(mapStrobe4), .mapIn(mapIn4),
    .logicalData(logicalData4), .logicalValid(logicalValid4),
    .physicalData(physicalData4), .physicalValid(physicalValid4),
    .activeMap(activeMap4), .mapBusy(mapBusy4), .mapError(mapError4), .mapDropped(mapDropped4)
  );

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe8(input logic [31:0] map);
    mapIn     = map;
    mapStrobe = 1'b1;
    tick();
    mapStrobe = 1'b0;
  endtask

  task automatic strobe4(input logic [31:0] map);
    mapIn4     = map;
    mapStrobe4 = 1'b1;
    tick();
    mapStrobe4 = 1'b0;
  endtask

  initial begin
    resetN = 1'b0; mapStrobe = 1'b0; mapStrobe4 = 1'b0; mapIn = '0; mapIn4 = '0;
    logicalValid = 8'hFF; logicalValid4 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      logicalData[16*i +: 16] = 16'(16'h1000 + i);
      expRev[16*i +: 16]      = 16'(16'h1007 - i);
    end
    for (int i = 0; i < 4; i++) begin
      logicalData4[16*i +: 16] = 16'(16'h2000 + i);
      expRev4[16*i +: 16]      = 16'(16'h2003 - i);
    end
    expId = logicalData;

    // Reset state
    tick(); tick();
    checkVal("rst_data",    128'(physicalData),  128'(0));
    checkVal("rst_valid",   128'(physicalValid), 128'(0));
    checkVal("rst_map",     128'(activeMap),     128'(ID8));
    checkVal("rst_flags",   128'({mapBusy, mapError, mapDropped}), 128'(0));
    checkVal("rst_map4",    128'(activeMap4),    128'(ID4));
    @(negedge clk) resetN = 1'b1;
    tick();
    checkVal("id_data",  128'(physicalData),  128'(expId));
    checkVal("id_valid", 128'(physicalValid), 128'(8'hFF));

    // Reversal load: 12-cycle busy window, valids blanked after edges 9..12
    strobe8(REV8);
    checkVal("rev_busy_e0", 128'(mapBusy), 128'(1));
    for (int e = 1; e <= 12; e++) begin
      tick();
      checkVal($sformatf("rev_busy_e%0d", e),  128'(mapBusy), 128'(e < 12));
      checkVal($sformatf("rev_valid_e%0d", e), 128'(physicalValid), (e >= 9) ? 128'(0) : 128'(8'hFF));
      checkVal($sformatf("rev_data_e%0d", e),  128'(physicalData), expId);
      checkVal($sformatf("rev_map_e%0d", e),   128'(activeMap), (e < 12) ? 128'(ID8) : 128'(REV8));
    end
    tick();
    checkVal("rev_data_new",  128'(physicalData),  expRev);
    checkVal("rev_valid_new", 128'(physicalValid), 128'(8'hFF));

    // Duplicate field: rejected at edge 8, active map untouched, valids never drop
    strobe8(DUP8);
    for (int e = 1; e <= 8; e++) begin
      tick();
      checkVal($sformatf("dup_err_e%0d", e),   128'(mapError), 128'(e == 8));
      checkVal($sformatf("dup_busy_e%0d", e),  128'(mapBusy), 128'(e < 8));
      checkVal($sformatf("dup_valid_e%0d", e), 128'(physicalValid), 128'(8'hFF));
      checkVal($sformatf("dup_data_e%0d", e),  128'(physicalData), expRev);
    end
    tick();
    checkVal("dup_err_sticky", 128'(mapError),  128'(1));
    checkVal("dup_map",        128'(activeMap), 128'(REV8));

    // Second strobe 3 cycles in is dropped; first map commits and clears both flags
    strobe8(ID8);
    tick(); tick();
    mapIn = REV8; mapStrobe = 1'b1;
    tick();
    mapStrobe = 1'b0;
    checkVal("drop_set",      128'(mapDropped), 128'(1));
    checkVal("drop_err_kept", 128'(mapError),   128'(1));
    for (int e = 4; e <= 12; e++) begin
      tick();
      checkVal($sformatf("drop_flag_e%0d", e), 128'(mapDropped), 128'(e < 12));
      checkVal($sformatf("drop_err_e%0d", e),  128'(mapError),   128'(e < 12));
      checkVal($sformatf("drop_map_e%0d", e),  128'(activeMap), (e < 12) ? 128'(REV8) : 128'(ID8));
    end
    tick();
    checkVal("drop_data", 128'(physicalData), expId);
    checkVal("drop_idle", 128'(mapBusy),      128'(0));

    // Strobe on the commit edge is lost and mapDropped ends cleared
    strobe8(REV8);
    for (int e = 1; e <= 11; e++) tick();
    mapIn = ID8; mapStrobe = 1'b1;
    tick();
    mapStrobe = 1'b0;
    checkVal("cedge_drop", 128'(mapDropped), 128'(0));
    checkVal("cedge_busy", 128'(mapBusy),    128'(0));
    checkVal("cedge_map",  128'(activeMap),  128'(REV8));
    tick();
    checkVal("cedge_lost", 128'(mapBusy),      128'(0));
    checkVal("cedge_data", 128'(physicalData), expRev);

    // Four-channel instance: out-of-range field, then a valid map with junk upper bits
    strobe4(32'h00000748);
    for (int e = 1; e <= 4; e++) tick();
    checkVal("n4_err",  128'(mapError4),  128'(1));
    checkVal("n4_busy", 128'(mapBusy4),   128'(0));
    checkVal("n4_map",  128'(activeMap4), 128'(ID4));
    strobe4(32'hFFFFF053);
    for (int e = 1; e <= 8; e++) tick();
    checkVal("n4_err_clr", 128'(mapError4),  128'(0));
    checkVal("n4_map_new", 128'(activeMap4), 128'(32'h053));
    tick();
    checkVal("n4_data",  128'(physicalData4),  128'(expRev4));
    checkVal("n4_valid", 128'(physicalValid4), 128'(4'hF));

    // Reset during CHECK abandons the load; next load works
    strobe8(ID8);
    for (int e = 1; e <= 5; e++) tick();
    resetN = 1'b0;
    #1;
    checkVal("mid_rst_map",   128'(activeMap),     128'(ID8));
    checkVal("mid_rst_data",  128'(physicalData),  128'(0));
    checkVal("mid_rst_valid", 128'(physicalValid), 128'(0));
    checkVal("mid_rst_flags", 128'({mapBusy, mapError, mapDropped}), 128'(0));
    @(negedge clk) resetN = 1'b1;
    tick();
    checkVal("post_rst_data", 128'(physicalData), expId);
    strobe8(REV8);
    for (int e = 1; e <= 12; e++) tick();
    checkVal("post_rst_busy", 128'(mapBusy),   128'(0));
    checkVal("post_rst_map",  128'(activeMap), 128'(REV8));
    tick();
    checkVal("post_rst_rev",  128'(physicalData), expRev);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
